// File: rtl/csa_pkg.sv
// Shared definitions for the bit-serial carry-select adder: FSM encodings
// and the default operand width.
package csa_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : csa_pkg

// File: rtl/carry_select_adder_1bit.sv
// One-bit carry-select cell: both carry-in outcomes are precomputed and the
// real carry-in picks one of them.
module carry_select_adder_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic c_o
);

  logic sum_c0, sum_c1, carry_c0, carry_c1;

  assign sum_c0   = a_i ^ b_i;
  assign carry_c0 = a_i & b_i;
  assign sum_c1   = ~(a_i ^ b_i);
  assign carry_c1 = a_i | b_i;

  assign sum_o = c_i ? sum_c1   : sum_c0;
  assign c_o   = c_i ? carry_c1 : carry_c0;

endmodule : carry_select_adder_1bit

// File: rtl/csa_serial_adder.sv
// Bit-serial adder: operands are consumed LSB first, one bit per clock, through
// a single carry-select cell; the result is published on entry to DONE.
module csa_serial_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_input,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic             carry_q, c_out_q;
  logic [CW-1:0]    cnt_q;

  logic             cell_sum, cell_carry;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  carry_select_adder_1bit u_cell (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .c_i  (carry_q),
    .sum_o(cell_sum),
    .c_o  (cell_carry)
  );

  // The result fills from the MSB end, so after WIDTH shifts bit 0 is in place.
  assign res_d    = (res_q >> 1) | {cell_sum, {(WIDTH-1){1'b0}}};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // NOTE: all state is updated with non-blocking assignments so every register
  // in this block sees the pre-edge values of the others, regardless of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= SHIFT;
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_input;
            res_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          res_q   <= res_d;
          carry_q <= cell_carry;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            state_q <= DONE;
            sum_q   <= res_d;
            c_out_q <= cell_carry;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule : csa_serial_adder

// File: tb/tb_csa_serial_adder.sv
// Directed and swept checks of csa_serial_adder at WIDTH=8 and WIDTH=16.
module tb_csa_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic        start8, c8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, c16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  csa_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_input(c8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  csa_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .c_input(c16),
    .busy(busy16), .done(done16), .sum(sum16), .c_out(cout16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  // poke > 0 pulses start with junk operands at that SHIFT cycle.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [8:0] exp, input int poke);
    int lat, nbusy;
    start8 = 1'b1; a8 = a; b8 = b; c8 = c;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1; nbusy = 0;
    while (!done8 && lat < 40) begin
      if (busy8) nbusy++;
      start8 = (lat == poke);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    check({tag, "_lat"}, lat, 9);
    check({tag, "_busy"}, nbusy, 8);
    check({tag, "_res"}, {cout8, sum8}, exp);
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [16:0] exp);
    int lat;
    start16 = 1'b1; a16 = a; b16 = b; c16 = c;
    @(negedge clk);
    start16 = 1'b0;
    lat = 1;
    while (!done16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 17);
    check({tag, "_res"}, {cout16, sum16}, exp);
  endtask

  // One idle cycle later: done must have dropped and the result must hold.
  task automatic idle8(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, done8, 1'b0);
    check({tag, "_idle_busy"}, busy8, 1'b0);
    check({tag, "_hold"}, {cout8, sum8}, exp);
  endtask

  initial begin
    int ndone;
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;
    logic        rc;

    rst = 1'b1;
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1;
    start16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; c16 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_res8", {cout8, sum8}, 9'h000);
    check("rst_busy16", busy16, 1'b0);
    check("rst_res16", {cout16, sum16}, 17'h0);
    rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
    @(negedge clk);

    op8("basic", 8'h5A, 8'h3C, 1'b0, 9'h096, 0);
    idle8("basic", 9'h096);
    @(negedge clk);
    op8("ripple", 8'hFF, 8'h00, 1'b1, 9'h100, 0);
    idle8("ripple", 9'h100);
    op8("carry_both", 8'h80, 8'h80, 1'b1, 9'h101, 0);
    // Start held through DONE: the second op begins without an IDLE cycle.
    op8("b2b", 8'h01, 8'h01, 1'b0, 9'h002, 0);
    idle8("b2b", 9'h002);
    op8("poke", 8'h12, 8'h34, 1'b0, 9'h046, 3);
    idle8("poke", 9'h046);

    // Reset on the 4th SHIFT cycle abandons the operation.
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; c8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", busy8, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy8, 1'b0);
    check("mid_rst_done", done8, 1'b0);
    check("mid_rst_res", {cout8, sum8}, 9'h000);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("mid_rst_no_done", ndone, 0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      @(negedge clk);
      op8("rnd8", ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), 0);
    end

    @(negedge clk);
    op16("ripple16", 16'hFFFF, 16'h0000, 1'b1, 17'h10000);
    @(negedge clk);
    op16("mix16", 16'h1234, 16'h4321, 1'b0, 17'h05555);
    @(negedge clk);
    check("idle16_done", done16, 1'b0);
    check("idle16_hold", {cout16, sum16}, 17'h05555);
    for (int i = 0; i < 1000; i++) begin
      wa = 16'($urandom); wb = 16'($urandom); rc = 1'($urandom);
      @(negedge clk);
      op16("rnd16", wa, wb, rc, 17'(wa) + 17'(wb) + 17'(rc));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_csa_serial_adder

// File: doc/csa_serial_adder.md
CSA_SERIAL_ADDER -- requirements
Module: csa_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports: clk and rst.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE or DONE.
REQ-006 SHALL have port a  input  WIDTH  operand A; captured on an accepted start.
REQ-007 SHALL have port b  input  WIDTH  operand B; captured on an accepted start.
REQ-008 SHALL have port c_input  input  1  carry-in; captured on an accepted start.
REQ-009 SHALL have port busy  output  1  high while bits are being processed (SHIFT state).
REQ-010 SHALL have port done  output  1  single-cycle pulse when sum and c_out become valid.
REQ-011 SHALL have port sum  output  WIDTH  registered result, held until the next accepted start or reset.
REQ-012 SHALL have port c_out  output  1  registered final carry, held like sum.

Function
REQ-013 SHALL add the operands bit-serially, LSB first, one bit per clock, through a single 1-bit carry-select cell.
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 IDLE: start=1 SHALL move the FSM to SHIFT and capture a, b and c_input into the operand shift registers and carry register; the bit counter SHALL be cleared to 0.
REQ-016 SHIFT: each cycle SHALL feed operand LSBs and the carry register to the cell, shift the cell sum into the result register MSB (result shifts right), load the cell carry into the carry register, shift both operands right, and increment the counter.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; on the cycle that processes bit WIDTH-1, the FSM SHALL move to DONE.
REQ-018 DONE SHALL last one cycle with done=1. sum SHALL equal (a+b+c_input) mod 2^WIDTH, and c_out SHALL equal bit WIDTH of the full sum.
REQ-019 DONE with start=0 SHALL go to IDLE; DONE with start=1 SHALL accept a new operation exactly as IDLE does (back-to-back).
REQ-020 Latency: start accepted at edge T SHALL give done=1 in the cycle after edge T+WIDTH, i.e. WIDTH+1 cycles after the start cycle.
REQ-021 start SHALL be ignored while busy=1; operand inputs SHALL be don't-care outside an accepted start.
REQ-022 sum and c_out SHALL update only on the transition into DONE and SHALL stay stable in IDLE.
REQ-023 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE); both SHALL be glitch-free, decoded from registered state.
REQ-024 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.

Reset
REQ-025 rst=1 SHALL, on the next clk edge, force the state to IDLE and clear busy, done, sum, c_out, the counter, the operand registers and the carry register to 0.
REQ-026 rst asserted mid-SHIFT SHALL abandon the operation without a done pulse, and no partial result SHALL appear on sum.
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 State encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL live in a shared package/include csa_pkg alongside the default WIDTH constant.
REQ-029 SHALL instantiate exactly one existing carry_select_adder_1bit as the sole arithmetic sub-module, with no other adder logic.

Verification
REQ-030 WIDTH=8, a=8'h5A, b=8'h3C, c_input=0, start pulsed -> busy for 8 cycles, done at cycle 9, sum=8'h96, c_out=0.
REQ-031 a=8'hFF, b=8'h00, c_input=1 -> sum=8'h00, c_out=1 (full carry ripple).
REQ-032 Back-to-back: start held through DONE with new operands 8'h01+8'h01 -> second done 9 cycles after the first, sum=8'h02; no IDLE cycle in between.
REQ-033 rst asserted at cycle 4 of SHIFT -> next cycle IDLE, busy=0, sum=0, c_out=0, and no done pulse.
REQ-034 start pulses during SHIFT -> ignored; result and latency match the original operands.
REQ-035 Random sweep of 1000 operand/carry triples at WIDTH=8 and WIDTH=16 -> {c_out,sum} equals a+b+c_input on every done.
